// File: rtl/tlb_code_responder.sv
`default_nettype none
// tlb_code_responder -- fully-associative code TLB responder: 1-cycle hits, page-walk fill on miss. Rev 1.0
// Optional feature: define TLB_CODE_STATS_EN to add the stat_hits/stat_misses counters.
module tlb_code_responder #(
  parameter int ENTRIES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pr_reset,
  input  logic        cr0_pg,
  input  logic        cr0_cd,
  input  logic        tlbflushall_do,
  input  logic        tlbcoderequest_do,
  input  logic [31:0] tlbcoderequest_address,
  input  logic        tlbcoderequest_su,
  output logic        tlbcode_do,
  output logic [31:0] tlbcode_linear,
  output logic [31:0] tlbcode_physical,
  output logic        tlbcode_cache_disable,
  output logic        tlbcode_pf,
  output logic        walk_do,
  output logic [31:0] walk_address,
  output logic        walk_su,
  input  logic        walk_done,
  input  logic        walk_fault,
  input  logic [19:0] walk_frame,
  input  logic        walk_user,
  input  logic        walk_cache_disable
`ifdef TLB_CODE_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses
`endif
);
  localparam int IDXW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESP  = 2'd1,
    S_WALK  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic               su_q, su_d;
  logic [31:0]        phys_q, phys_d;
  logic               cd_q, cd_d;
  logic               aborted_q, aborted_d;
  logic               flush_seen_q, flush_seen_d;
  logic [IDXW-1:0]    ptr_q, ptr_d;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ENTRIES-1:0] user_q, user_d;
  logic [ENTRIES-1:0] pcd_q, pcd_d;
  logic [19:0]        tag_q   [ENTRIES];
  logic [19:0]        tag_d   [ENTRIES];
  logic [19:0]        frame_q [ENTRIES];
  logic [19:0]        frame_d [ENTRIES];

  logic               hit;
  logic [19:0]        hit_frame;
  logic               hit_pcd;
  logic               abort_now;

  // Lookup is done on the live request inputs so a hit answers the very next cycle.
  always_comb begin
    hit       = 1'b0;
    hit_frame = '0;
    hit_pcd   = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (tag_q[i] == tlbcoderequest_address[31:12]) &&
          (!tlbcoderequest_su || user_q[i])) begin
        hit       = 1'b1;
        hit_frame = frame_q[i];
        hit_pcd   = pcd_q[i];
      end
    end
  end

  assign abort_now = aborted_q | pr_reset;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    su_d         = su_q;
    phys_d       = phys_q;
    cd_d         = cd_q;
    aborted_d    = aborted_q;
    flush_seen_d = flush_seen_q;
    ptr_d        = ptr_q;
    valid_d      = valid_q;
    user_d       = user_q;
    pcd_d        = pcd_q;
    tag_d        = tag_q;
    frame_d      = frame_q;

    case (state_q)
      S_IDLE: begin
        if (tlbcoderequest_do && !pr_reset) begin
          addr_d = tlbcoderequest_address;
          su_d   = tlbcoderequest_su;
          if (!cr0_pg) begin
            phys_d  = tlbcoderequest_address;
            cd_d    = cr0_cd;
            state_d = S_RESP;
          end else if (hit) begin
            phys_d  = {hit_frame, tlbcoderequest_address[11:0]};
            cd_d    = hit_pcd;
            state_d = S_RESP;
          end else begin
            state_d = S_WALK;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      S_WALK: begin
        if (pr_reset)       aborted_d    = 1'b1;
        if (tlbflushall_do) flush_seen_d = 1'b1;
        if (walk_done) begin
          aborted_d    = 1'b0;
          flush_seen_d = 1'b0;
          if (walk_fault) begin
            state_d = abort_now ? S_IDLE : S_FAULT;
          end else begin
            // An aborted walk still fills: the translation itself is valid.
            if (!flush_seen_q) begin
              valid_d[ptr_q] = 1'b1;
              tag_d[ptr_q]   = addr_q[31:12];
              frame_d[ptr_q] = walk_frame;
              user_d[ptr_q]  = walk_user;
              pcd_d[ptr_q]   = walk_cache_disable;
            end
            ptr_d   = ptr_q + IDXW'(1);
            phys_d  = {walk_frame, addr_q[11:0]};
            cd_d    = walk_cache_disable;
            state_d = abort_now ? S_IDLE : S_RESP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush overrides any fill made in the same cycle.
    if (tlbflushall_do) valid_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      su_q         <= 1'b0;
      phys_q       <= '0;
      cd_q         <= 1'b0;
      aborted_q    <= 1'b0;
      flush_seen_q <= 1'b0;
      ptr_q        <= '0;
      valid_q      <= '0;
      user_q       <= '0;
      pcd_q        <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]   <= '0;
        frame_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      su_q         <= su_d;
      phys_q       <= phys_d;
      cd_q         <= cd_d;
      aborted_q    <= aborted_d;
      flush_seen_q <= flush_seen_d;
      ptr_q        <= ptr_d;
      valid_q      <= valid_d;
      user_q       <= user_d;
      pcd_q        <= pcd_d;
      tag_q        <= tag_d;
      frame_q      <= frame_d;
    end
  end

  assign tlbcode_do            = (state_q == S_RESP);
  assign tlbcode_pf            = (state_q == S_FAULT);
  assign tlbcode_linear        = addr_q;
  assign tlbcode_physical      = phys_q;
  assign tlbcode_cache_disable = cd_q;
  assign walk_do               = (state_q == S_WALK);
  assign walk_address          = addr_q;
  assign walk_su               = su_q;

`ifdef TLB_CODE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (state_q == S_IDLE) begin
      if (state_d == S_RESP) stat_hits   <= stat_hits + 32'd1;
      if (state_d == S_WALK) stat_misses <= stat_misses + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tlb_code_responder.sv
`default_nettype none
// tb_tlb_code_responder -- scoreboard bench for the code TLB responder (expected results queued at stimulus time).
module tb_tlb_code_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pr_reset = 1'b0;
  logic        cr0_pg = 1'b0;
  logic        cr0_cd = 1'b0;
  logic        tlbflushall_do = 1'b0;
  logic        req_do = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_su = 1'b0;
  logic        tlbcode_do;
  logic [31:0] tlbcode_linear;
  logic [31:0] tlbcode_physical;
  logic        tlbcode_cache_disable;
  logic        tlbcode_pf;
  logic        walk_do;
  logic [31:0] walk_address;
  logic        walk_su;
  logic        walk_done = 1'b0;
  logic        walk_fault = 1'b0;
  logic [19:0] walk_frame = '0;
  logic        walk_user = 1'b0;
  logic        walk_cd = 1'b0;
`ifdef TLB_CODE_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  tlb_code_responder #(.ENTRIES(8)) dut (
    .clk(clk), .rst_n(rst_n), .pr_reset(pr_reset), .cr0_pg(cr0_pg), .cr0_cd(cr0_cd),
    .tlbflushall_do(tlbflushall_do), .tlbcoderequest_do(req_do),
    .tlbcoderequest_address(req_addr), .tlbcoderequest_su(req_su),
    .tlbcode_do(tlbcode_do), .tlbcode_linear(tlbcode_linear), .tlbcode_physical(tlbcode_physical),
    .tlbcode_cache_disable(tlbcode_cache_disable), .tlbcode_pf(tlbcode_pf),
    .walk_do(walk_do), .walk_address(walk_address), .walk_su(walk_su),
    .walk_done(walk_done), .walk_fault(walk_fault), .walk_frame(walk_frame),
    .walk_user(walk_user), .walk_cache_disable(walk_cd)
`ifdef TLB_CODE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          exp_do;
    bit          exp_pf;
    int          lat;
    int          walks;
    logic [31:0] lin;
    logic [31:0] phys;
    bit          cd;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Drives one request, plays the page walker and records what the DUT answered.
  // abort_at/flush_at: walk cycle to pulse pr_reset/flush (0 = never, flush_at<0 = with walk_done).
  task automatic run_req(input logic [31:0] a, input bit s, input int lat, input logic [19:0] fr,
                         input bit flt, input bit usr, input bit pcd, input int abort_at,
                         input int flush_at, output int resp_k, output int wcyc, output bit gdo,
                         output bit gpf, output logic [31:0] olin, output logic [31:0] ophys,
                         output bit ocd, output bit waddr_ok);
    int done_k;
    bit aborted;
    resp_k = 0; wcyc = 0; gdo = 0; gpf = 0; olin = '0; ophys = '0; ocd = 0; waddr_ok = 1;
    done_k = 0; aborted = 0;
    @(negedge clk);
    req_do = 1'b1; req_addr = a; req_su = s;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      walk_done = 1'b0; tlbflushall_do = 1'b0; pr_reset = 1'b0;
      if (tlbcode_do) begin
        gdo = 1; resp_k = k; olin = tlbcode_linear; ophys = tlbcode_physical;
        ocd = tlbcode_cache_disable; req_do = 1'b0;
        break;
      end
      if (tlbcode_pf) begin
        gpf = 1; resp_k = k; req_do = 1'b0;
        break;
      end
      if (walk_do) begin
        wcyc++;
        if (walk_address !== a || walk_su !== s) waddr_ok = 0;
        if (abort_at > 0 && wcyc == abort_at) begin pr_reset = 1'b1; req_do = 1'b0; aborted = 1; end
        if (flush_at > 0 && wcyc == flush_at) tlbflushall_do = 1'b1;
        if (wcyc == lat) begin
          walk_done = 1'b1; walk_fault = flt; walk_frame = fr; walk_user = usr; walk_cd = pcd;
          if (flush_at < 0) tlbflushall_do = 1'b1;
          done_k = k;
        end
      end
      if (aborted && done_k > 0 && k >= done_k + 4) break;
    end
    walk_done = 1'b0; tlbflushall_do = 1'b0; pr_reset = 1'b0; req_do = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({tlbcode_do, tlbcode_pf, walk_do} !== 3'b000)
      $display("FAIL reset_ctl: do/pf/walk=%b required 000", {tlbcode_do, tlbcode_pf, walk_do});
    else n_pass++;
    n_chk++;
    if (tlbcode_physical !== 32'h0 || tlbcode_linear !== 32'h0 || tlbcode_cache_disable !== 1'b0)
      $display("FAIL reset_data: phys=%h lin=%h cd=%b required 0", tlbcode_physical, tlbcode_linear,
               tlbcode_cache_disable);
    else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({tlbcode_do, tlbcode_pf, walk_do} !== 3'b000 || walk_address !== 32'h0)
      $display("FAIL reset_release: do/pf/walk=%b addr=%h required 000/0",
               {tlbcode_do, tlbcode_pf, walk_do}, walk_address);
    else n_pass++;
  endtask

  task automatic test_nopaging();
    int rk, wc; bit gdo, gpf, cd, wok; logic [31:0] lin, ph; exp_t e;
    cr0_pg = 1'b0; cr0_cd = 1'b1;
    sb.push_back('{1, 0, 1, 0, 32'h0001_2345, 32'h0001_2345, 1});
    run_req(32'h0001_2345, 0, 5, 20'h0, 0, 0, 0, 0, 0, rk, wc, gdo, gpf, lin, ph, cd, wok);
    e = sb.pop_front();
    n_chk++;
    if (gdo !== e.exp_do || gpf !== e.exp_pf || rk != e.lat)
      $display("FAIL nopg_resp: do=%0b pf=%0b lat=%0d required do=1 pf=0 lat=%0d", gdo, gpf, rk, e.lat);
    else n_pass++;
    n_chk++;
    if (ph !== e.phys || lin !== e.lin || cd !== e.cd || wc != e.walks)
      $display("FAIL nopg_data: phys=%h lin=%h cd=%0b walks=%0d required %h %h %0b %0d",
               ph, lin, cd, wc, e.phys, e.lin, e.cd, e.walks);
    else n_pass++;
    cr0_cd = 1'b0;
  endtask

  task automatic test_walk_hit();
    int rk, wc; bit gdo, gpf, cd, wok; logic [31:0] lin, ph; exp_t e;
    cr0_pg = 1'b1;
    sb.push_back('{1, 0, 6, 5, 32'h0040_1010, 32'h1234_5010, 0});
    run_req(32'h0040_1010, 0, 5, 20'h12345, 0, 1, 0, 0, 0, rk, wc, gdo, gpf, lin, ph, cd, wok);
    e = sb.pop_front();
    n_chk++;
    if (gdo !== 1'b1 || rk != e.lat || wc != e.walks || wok !== 1'b1)
      $display("FAIL miss_timing: do=%0b lat=%0d walk_cycles=%0d addr_ok=%0b required 1 %0d %0d 1",
               gdo, rk, wc, wok, e.lat, e.walks);
    else n_pass++;
    n_chk++;
    if (ph !== e.phys || cd !== e.cd || lin !== e.lin)
      $display("FAIL miss_data: phys=%h cd=%0b lin=%h required %h %0b %h", ph, cd, lin, e.phys, e.cd, e.lin);
    else n_pass++;
    sb.push_back('{1, 0, 1, 0, 32'h0040_1FF0, 32'h1234_5FF0, 0});
    run_req(32'h0040_1FF0, 0, 5, 20'h0, 0, 0, 0, 0, 0, rk, wc, gdo, gpf, lin, ph, cd, wok);
    e = sb.pop_front();
    n_chk++;
    if (gdo !== 1'b1 || rk != e.lat || wc != e.walks || ph !== e.phys)
      $display("FAIL hit: do=%0b lat=%0d walks=%0d phys=%h required 1 %0d %0d %h",
               gdo, rk, wc, ph, e.lat, e.walks, e.phys);
    else n_pass++;
  endtask

  task automatic test_fault();
    int rk, wc; bit gdo, gpf, cd, wok; logic [31:0] lin, ph; exp_t e;
    sb.push_back('{0, 1, 4, 3, 32'h0060_0ABC, 32'h0, 0});
    run_req(32'h0060_0ABC, 0, 3, 20'h0, 1, 0, 0, 0, 0, rk, wc, gdo, gpf, lin, ph, cd, wok);
    e = sb.pop_front();
    n_chk++;
    if (gdo !== e.exp_do || gpf !== e.exp_pf || rk != e.lat || wc != e.walks)
      $display("FAIL fault_pf: do=%0b pf=%0b lat=%0d walks=%0d required 0 1 %0d %0d",
               gdo, gpf, rk, wc, e.lat, e.walks);
    else n_pass++;
    n_chk++;
    @(negedge clk);
    if (tlbcode_pf !== 1'b0 || tlbcode_do !== 1'b0)
      $display("FAIL fault_single: pf=%0b do=%0b after pulse required 0 0", tlbcode_pf, tlbcode_do);
    else n_pass++;
    sb.push_back('{1, 0, 4, 3, 32'h0060_0ABC, 32'hABCD_EABC, 1});
    run_req(32'h0060_0ABC, 0, 3, 20'hABCDE, 0, 1, 1, 0, 0, rk, wc, gdo, gpf, lin, ph, cd, wok);
    e = sb.pop_front();
    n_chk++;
    if (gdo !== 1'b1 || wc != e.walks || ph !== e.phys || cd !== e.cd)
      $display("FAIL fault_retry: do=%0b walks=%0d phys=%h cd=%0b required 1 %0d %h %0b",
               gdo, wc, ph, cd, e.walks, e.phys, e.cd);
    else n_pass++;
    // Supervisor-only page: user request must miss and let the walker fault it.
    sb.push_back('{1, 0, 3, 2, 32'h0050_0000, 32'h5555_5000, 0});
    run_req(32'h0050_0000, 0, 2, 20'h55555, 0, 0, 0, 0, 0, rk, wc, gdo, gpf, lin, ph, cd, wok);
    e = sb.pop_front();
    sb.push_back('{0, 1, 3, 2, 32'h0050_0010, 32'h0, 0});
    run_req(32'h0050_0010, 1, 2, 20'h0, 1, 0, 0, 0, 0, rk, wc, gdo, gpf, lin, ph, cd, wok);
    e = sb.pop_front();
    n_chk++;
    if (wc != e.walks || gpf !== e.exp_pf || gdo !== e.exp_do || wok !== 1'b1)
      $display("FAIL user_on_sup: walks=%0d pf=%0b do=%0b su_ok=%0b required %0d 1 0 1", wc, gpf, gdo, wok, e.walks);
    else n_pass++;
    sb.push_back('{1, 0, 1, 0, 32'h0050_0020, 32'h5555_5020, 0});
    run_req(32'h0050_0020, 0, 2, 20'h0, 0, 0, 0, 0, 0, rk, wc, gdo, gpf, lin, ph, cd, wok);
    e = sb.pop_front();
    n_chk++;
    if (gdo !== 1'b1 || rk != e.lat || ph !== e.phys)
      $display("FAIL sup_hit: do=%0b lat=%0d phys=%h required 1 %0d %h", gdo, rk, ph, e.lat, e.phys);
    else n_pass++;
  endtask

  task automatic test_abort();
    int rk, wc; bit gdo, gpf, cd, wok; logic [31:0] lin, ph; exp_t e;
    sb.push_back('{0, 0, 0, 4, 32'h0070_0123, 32'h0, 0});
    run_req(32'h0070_0123, 0, 4, 20'h77777, 0, 1, 0, 2, 0, rk, wc, gdo, gpf, lin, ph, cd, wok);
    e = sb.pop_front();
    n_chk++;
    if (gdo !== e.exp_do || gpf !== e.exp_pf || wc != e.walks)
      $display("FAIL abort: do=%0b pf=%0b walks=%0d required 0 0 %0d", gdo, gpf, wc, e.walks);
    else n_pass++;
    sb.push_back('{1, 0, 1, 0, 32'h0070_0456, 32'h7777_7456, 0});
    run_req(32'h0070_0456, 0, 4, 20'h0, 0, 0, 0, 0, 0, rk, wc, gdo, gpf, lin, ph, cd, wok);
    e = sb.pop_front();
    n_chk++;
    if (gdo !== 1'b1 || rk != e.lat || ph !== e.phys)
      $display("FAIL abort_fill: do=%0b lat=%0d phys=%h required 1 %0d %h", gdo, rk, ph, e.lat, e.phys);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    sb.push_back('{1, 0, 1, 0, 32'h0040_1234, 32'h1234_5234, 0});
    sb.push_back('{1, 0, 1, 0, 32'h0070_0888, 32'h7777_7888, 0});
    @(negedge clk);
    req_do = 1'b1; req_addr = 32'h0040_1234; req_su = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    n_chk++;
    if (tlbcode_do !== 1'b1 || tlbcode_physical !== e.phys || tlbcode_linear !== e.lin)
      $display("FAIL b2b_first: do=%0b phys=%h lin=%h required 1 %h %h",
               tlbcode_do, tlbcode_physical, tlbcode_linear, e.phys, e.lin);
    else n_pass++;
    req_addr = 32'h0070_0888;
    @(negedge clk);
    n_chk++;
    if (tlbcode_do !== 1'b0)
      $display("FAIL b2b_gap: do=%0b required 0", tlbcode_do);
    else n_pass++;
    @(negedge clk);
    e = sb.pop_front();
    n_chk++;
    if (tlbcode_do !== 1'b1 || tlbcode_physical !== e.phys || tlbcode_linear !== e.lin)
      $display("FAIL b2b_second: do=%0b phys=%h lin=%h required 1 %h %h",
               tlbcode_do, tlbcode_physical, tlbcode_linear, e.phys, e.lin);
    else n_pass++;
    req_do = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_replacement();
    int rk, wc; bit gdo, gpf, cd, wok; logic [31:0] lin, ph, a; exp_t e;
    @(negedge clk); tlbflushall_do = 1'b1;
    @(negedge clk); tlbflushall_do = 1'b0;
    for (int i = 0; i < 9; i++) begin
      a = 32'h0100_0000 + (i << 12) + 32'h10;
      sb.push_back('{1, 0, 3, 2, a, {20'h80000 + 20'(i), 12'h010}, 0});
      run_req(a, 0, 2, 20'h80000 + 20'(i), 0, 1, 0, 0, 0, rk, wc, gdo, gpf, lin, ph, cd, wok);
      e = sb.pop_front();
      n_chk++;
      if (gdo !== 1'b1 || wc != e.walks || ph !== e.phys)
        $display("FAIL fill_%0d: do=%0b walks=%0d phys=%h required 1 %0d %h", i, gdo, wc, ph, e.walks, e.phys);
      else n_pass++;
    end
    for (int i = 1; i < 9; i++) begin
      a = 32'h0100_0000 + (i << 12) + 32'h20;
      sb.push_back('{1, 0, 1, 0, a, {20'h80000 + 20'(i), 12'h020}, 0});
      run_req(a, 0, 2, 20'h0, 0, 1, 0, 0, 0, rk, wc, gdo, gpf, lin, ph, cd, wok);
      e = sb.pop_front();
      n_chk++;
      if (gdo !== 1'b1 || rk != e.lat || wc != e.walks || ph !== e.phys)
        $display("FAIL rr_hit_%0d: do=%0b lat=%0d walks=%0d phys=%h required 1 1 0 %h",
                 i, gdo, rk, wc, ph, e.phys);
      else n_pass++;
    end
    sb.push_back('{1, 0, 3, 2, 32'h0100_0030, 32'h8000_0030, 0});
    run_req(32'h0100_0030, 0, 2, 20'h80000, 0, 1, 0, 0, 0, rk, wc, gdo, gpf, lin, ph, cd, wok);
    e = sb.pop_front();
    n_chk++;
    if (wc != e.walks || rk != e.lat)
      $display("FAIL rr_evicted: walks=%0d lat=%0d required %0d %0d", wc, rk, e.walks, e.lat);
    else n_pass++;
  endtask

  task automatic test_flush();
    int rk, wc; bit gdo, gpf, cd, wok; logic [31:0] lin, ph; exp_t e;
    sb.push_back('{1, 0, 5, 4, 32'h00A0_0100, 32'h0AAAA100, 0});
    run_req(32'h00A0_0100, 0, 4, 20'h0AAAA, 0, 1, 0, 0, 2, rk, wc, gdo, gpf, lin, ph, cd, wok);
    e = sb.pop_front();
    n_chk++;
    if (gdo !== 1'b1 || rk != e.lat || ph !== e.phys)
      $display("FAIL flush_mid_resp: do=%0b lat=%0d phys=%h required 1 %0d %h", gdo, rk, ph, e.lat, e.phys);
    else n_pass++;
    sb.push_back('{1, 0, 2, 1, 32'h00A0_0200, 32'h0AAAA200, 0});
    run_req(32'h00A0_0200, 0, 1, 20'h0AAAA, 0, 1, 0, 0, 0, rk, wc, gdo, gpf, lin, ph, cd, wok);
    e = sb.pop_front();
    n_chk++;
    if (wc != e.walks || gdo !== 1'b1)
      $display("FAIL flush_mid_nofill: walks=%0d do=%0b required %0d 1", wc, gdo, e.walks);
    else n_pass++;
    sb.push_back('{1, 0, 4, 3, 32'h00B0_0300, 32'h0BBBB300, 1});
    run_req(32'h00B0_0300, 0, 3, 20'h0BBBB, 0, 1, 1, 0, -1, rk, wc, gdo, gpf, lin, ph, cd, wok);
    e = sb.pop_front();
    n_chk++;
    if (gdo !== 1'b1 || ph !== e.phys || cd !== e.cd)
      $display("FAIL flush_race_resp: do=%0b phys=%h cd=%0b required 1 %h %0b", gdo, ph, cd, e.phys, e.cd);
    else n_pass++;
    sb.push_back('{1, 0, 3, 2, 32'h00B0_0400, 32'h0BBBB400, 1});
    run_req(32'h00B0_0400, 0, 2, 20'h0BBBB, 0, 1, 1, 0, 0, rk, wc, gdo, gpf, lin, ph, cd, wok);
    e = sb.pop_front();
    n_chk++;
    if (wc != e.walks || rk != e.lat)
      $display("FAIL flush_race_nofill: walks=%0d lat=%0d required %0d %0d", wc, rk, e.walks, e.lat);
    else n_pass++;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nopaging();
    test_walk_hit();
    test_fault();
    test_abort();
    test_back_to_back();
    test_replacement();
    test_flush();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
